// File: rtl/mips_pipe_pkg.sv
// Shared pipeline-register definitions: occupancy states and the NOP bubble.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating up-counter with enable and async reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline register with optional two-entry skid buffer, flush and stall count.
import mips_pipe_pkg::*;

module pipe_skid_stage #(
  parameter int                 DATA_W = 64,
  parameter logic [DATA_W-1:0]  BUBBLE = DATA_W'(NOP),
  parameter int                 SKID   = 1,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_t       state;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              in_xfer;
  logic              out_xfer;

  // Skid mode breaks the out_ready -> in_ready path
  assign in_ready = (SKID != 0) ? !skid_valid
                                : (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= BUBBLE;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE;
    end else if (flush) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= BUBBLE;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= BUBBLE;
          end else if (in_xfer && (SKID != 0)) begin
            state      <= TWO;
            skid_valid <= 1'b1;
            skid_data  <= in_data;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state      <= ONE;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          out_data   <= BUBBLE;
          skid_valid <= 1'b0;
          skid_data  <= BUBBLE;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (out_valid && !out_ready),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed + randomized bench for pipe_skid_stage against a queue model.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;

  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [15:0] stall_cnt;

  logic        c3_in_ready;
  logic        c3_out_valid;
  logic [63:0] c3_out_data;
  logic [2:0]  c3_stall_cnt;

  logic        in0_valid = 1'b0;
  logic [63:0] in0_data = '0;
  logic        out0_ready = 1'b0;
  logic        in0_ready;
  logic        out0_valid;
  logic [63:0] out0_data;
  logic [15:0] stall0_cnt;

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.CNT_W(3)) dut_c3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c3_in_ready), .in_data(in_data),
    .out_valid(c3_out_valid), .out_ready(out_ready),
    .out_data(c3_out_data), .stall_cnt(c3_stall_cnt)
  );

  pipe_skid_stage #(.SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in0_valid), .in_ready(in0_ready), .in_data(in0_data),
    .out_valid(out0_valid), .out_ready(out0_ready),
    .out_data(out0_data), .stall_cnt(stall0_cnt)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] q1[$];
  logic [63:0] q0[$];
  int sc1 = 0;
  int sc3 = 0;
  int sc0 = 0;
  int sent0 = 0;
  int recv0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q1.delete();
    q0.delete();
    sc1 = 0;
    sc3 = 0;
    sc0 = 0;
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(q1.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q1.size() > 0));
    chk("out_data", out_data, (q1.size() > 0) ? q1[0] : 64'h0);
    chk("stall_cnt", 64'(stall_cnt), 64'(sc1));
    chk("c3_stall_cnt", 64'(c3_stall_cnt), 64'(sc3));
    chk("s0_in_ready", 64'(in0_ready),
        64'((q0.size() == 0) || out0_ready));
    chk("s0_out_valid", 64'(out0_valid), 64'(q0.size() > 0));
    chk("s0_out_data", out0_data, (q0.size() > 0) ? q0[0] : 64'h0);
    chk("s0_stall_cnt", 64'(stall0_cnt), 64'(sc0));
  endtask

  // Check current outputs, then advance one edge and update the model
  task automatic cycle();
    bit acc1, pop1, st1, acc0, pop0, st0;
    #1;
    check_all();
    acc1 = in_valid && (q1.size() < 2);
    pop1 = (q1.size() > 0) && out_ready;
    st1  = (q1.size() > 0) && !out_ready;
    acc0 = in0_valid && ((q0.size() == 0) || out0_ready);
    pop0 = (q0.size() > 0) && out0_ready;
    st0  = (q0.size() > 0) && !out0_ready;
    @(posedge clk);
    if (st1 && sc1 < 65535) sc1++;
    if (st1 && sc3 < 7) sc3++;
    if (st0 && sc0 < 65535) sc0++;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (acc1) q1.push_back(in_data);
      if (pop0) begin
        void'(q0.pop_front());
        recv0++;
      end
      if (acc0) begin
        q0.push_back(in0_data);
        sent0++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [63:0] D0 = 64'h0000_0004_2002_0005;
  localparam logic [63:0] DA = 64'h0000_0008_1111_aaaa;
  localparam logic [63:0] DB = 64'h0000_000c_2222_bbbb;
  localparam logic [63:0] DC = 64'h0000_0010_3333_cccc;

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    do_reset();

    // Single transfer, one-cycle latency
    in_valid = 1'b1;
    in_data = D0;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    #1;
    chk("lat_out_valid", 64'(out_valid), 64'h1);
    chk("lat_out_data", out_data, D0);
    chk("lat_in_ready", 64'(in_ready), 64'h1);
    cycle();
    cycle();

    // Fill to TWO under backpressure, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DA;
    cycle();
    in_data = DB;
    cycle();
    in_valid = 1'b0;
    #1;
    chk("two_in_ready", 64'(in_ready), 64'h0);
    chk("two_out_data", out_data, DA);
    cycle();
    out_ready = 1'b1;
    #1;
    chk("drain_a", out_data, DA);
    cycle();
    chk("drain_b", out_data, DB);
    cycle();
    chk("drain_empty", 64'(out_valid), 64'h0);

    // Flush in TWO with a same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DA;
    cycle();
    in_data = DB;
    cycle();
    in_data = DC;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'h0);
    chk("fl_out_data", out_data, 64'h0);
    chk("fl_in_ready", 64'(in_ready), 64'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_nothing", 64'(out_valid), 64'h0);
    end

    // Stall counting and saturation
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DA;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("stall5", 64'(stall_cnt), 64'd5);
    for (int i = 0; i < 5; i++) cycle();
    chk("stall10", 64'(stall_cnt), 64'd10);
    chk("stall_sat3", 64'(c3_stall_cnt), 64'd7);

    // Reset asserted between edges while in TWO
    in_valid = 1'b1;
    in_data = DB;
    cycle();
    in_valid = 1'b0;
    cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_out_data", out_data, 64'h0);
    chk("mid_rst_stall", 64'(stall_cnt), 64'h0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'h1);
    do_reset();
    out_ready = 1'b1;
    cycle();

    // Random traffic on both variants; SKID=0 with toggling out_ready
    sent0 = 0;
    recv0 = 0;
    for (int n = 0; n < 20000 && recv0 < 1000; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      in0_valid = (sent0 < 1000) && 1'($urandom_range(0, 1));
      in0_data = {$urandom, $urandom};
      out0_ready = ~out0_ready;
      cycle();
    end
    chk("s0_recv_1000", 64'(recv0), 64'd1000);
    chk("s0_sent_1000", 64'(sent0), 64'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
